// File: rtl/mult_booth_seq_if.sv
// Request/response bundle for the sequential Booth multiplier.
// The master drives operands and control; the slave returns status and product.
interface mult_booth_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_mode;
  logic             abort;
  logic [WIDTH-1:0] aInput;
  logic [WIDTH-1:0] bInput;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, signed_mode, abort, aInput, bInput,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, signed_mode, abort, aInput, bInput,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/mult_booth_seq.sv
// Radix-2 Booth multiplier, one step per clock, WIDTH+1 steps per product.
// Operands are widened by one bit so signed and unsigned share the same datapath.
module mult_booth_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic            clk,
  input  logic            reset,
  mult_booth_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH:0]   r_mult;
  logic [WIDTH:0]   r_mcand;
  logic             r_q1;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_acc_sh;
  logic [WIDTH:0]   w_mult_sh;
  logic [WIDTH:0]   w_ext_a;
  logic [WIDTH:0]   w_ext_b;
  logic             w_last;
  logic             w_accept;

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_sum = r_acc;
    case ({r_mult[0], r_q1})
      2'b10:   w_sum = r_acc - r_mcand;
      2'b01:   w_sum = r_acc + r_mcand;
      default: w_sum = r_acc;
    endcase
    w_acc_sh  = {w_sum[WIDTH], w_sum[WIDTH:1]};
    w_mult_sh = {w_sum[0], r_mult[WIDTH:1]};
  end

  assign w_ext_a  = {bus.signed_mode & bus.aInput[WIDTH-1], bus.aInput};
  assign w_ext_b  = {bus.signed_mode & bus.bInput[WIDTH-1], bus.bInput};
  assign w_last   = (r_cnt == CNT_W'(WIDTH));
  assign w_accept = bus.start & ~bus.abort;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: this design has no memory arrays, so every register is cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_mult  <= '0;
      r_mcand <= '0;
      r_q1    <= 1'b0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_mult  <= w_ext_a;
            r_mcand <= w_ext_b;
            r_acc   <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_acc  <= w_acc_sh;
            r_mult <= w_mult_sh;
            r_q1   <= r_mult[0];
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
              // Product is {acc,mult}; keep its low 2*WIDTH bits.
              r_lo    <= w_mult_sh[WIDTH-1:0];
              r_hi    <= {w_acc_sh[WIDTH-2:0], w_mult_sh[WIDTH]};
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule

// File: tb/tb_mult_booth_seq.sv
// Self-checking bench: 32-bit and 8-bit instances checked against a plain
// arithmetic product model plus directed corner cases.
module tb_mult_booth_seq;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mult_booth_seq_if #(.WIDTH(32)) bus32 ();
  mult_booth_seq_if #(.WIDTH(8))  bus8 ();

  mult_booth_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  mult_booth_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));

  function automatic logic [63:0] model32(logic [31:0] a, logic [31:0] b, logic sm);
    logic [63:0] ea, eb;
    ea = {{32{sm & a[31]}}, a};
    eb = {{32{sm & b[31]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [15:0] model8(logic [7:0] a, logic [7:0] b, logic sm);
    logic [15:0] ea, eb;
    ea = {{8{sm & a[7]}}, a};
    eb = {{8{sm & b[7]}}, b};
    return ea * eb;
  endfunction

  // Runs one 32-bit multiply; lat counts edges from the start edge (inclusive) to done seen.
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                      output logic [31:0] hi, output logic [31:0] lo,
                      output int lat, output logic busy_mid);
    @(negedge clk);
    bus32.aInput = a; bus32.bInput = b; bus32.signed_mode = sm; bus32.start = 1'b1;
    lat = 0;
    busy_mid = 1'b0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (lat == 1) begin
        bus32.start = 1'b0;
        bus32.aInput = $urandom; bus32.bInput = $urandom; bus32.signed_mode = ~sm;
      end
      if (lat == 5) busy_mid = bus32.busy;
    end while (bus32.done !== 1'b1 && lat < 100);
    hi = bus32.HI;
    lo = bus32.LO;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                     output logic [7:0] hi, output logic [7:0] lo, output int lat);
    @(negedge clk);
    bus8.aInput = a; bus8.bInput = b; bus8.signed_mode = sm; bus8.start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (lat == 1) begin
        bus8.start = 1'b0;
        bus8.aInput = 8'($urandom); bus8.bInput = 8'($urandom);
      end
    end while (bus8.done !== 1'b1 && lat < 100);
    hi = bus8.HI;
    lo = bus8.LO;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({bus32.busy, bus32.done, bus32.HI, bus32.LO} !== '0) begin
      n_errors++;
      $display("FAIL reset32 got busy=%b done=%b HI=%h LO=%h exp all zero",
               bus32.busy, bus32.done, bus32.HI, bus32.LO);
    end
    n_checks++;
    if ({bus8.busy, bus8.done, bus8.HI, bus8.LO} !== '0) begin
      n_errors++;
      $display("FAIL reset8 got busy=%b done=%b HI=%h LO=%h exp all zero",
               bus8.busy, bus8.done, bus8.HI, bus8.LO);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed32();
    logic [31:0] hi, lo;
    int lat;
    logic bm;
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, hi, lo, lat, bm);
    n_checks++;
    if (lat != 34 || hi !== 32'h0 || lo !== 32'h1) begin
      n_errors++;
      $display("FAIL s_m1xm1 got lat=%0d HI=%h LO=%h exp lat=34 HI=00000000 LO=00000001", lat, hi, lo);
    end
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, hi, lo, lat, bm);
    n_checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin
      n_errors++;
      $display("FAIL u_max got HI=%h LO=%h exp HI=fffffffe LO=00000001", hi, lo);
    end
    op32(32'h8000_0000, 32'h8000_0000, 1'b1, hi, lo, lat, bm);
    n_checks++;
    if (hi !== 32'h4000_0000 || lo !== 32'h0) begin
      n_errors++;
      $display("FAIL s_min2 got HI=%h LO=%h exp HI=40000000 LO=00000000", hi, lo);
    end
    op32(32'd7, 32'hFFFF_FFFD, 1'b1, hi, lo, lat, bm);
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      n_errors++;
      $display("FAIL s_7xm3 got HI=%h LO=%h exp HI=ffffffff LO=ffffffeb", hi, lo);
    end
  endtask

  task automatic test_random32();
    logic [31:0] a, b, hi, lo;
    logic [63:0] exp_p;
    logic sm, bm;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom; sm = 1'($urandom);
      if (i % 8 == 0) a = {a[31], 31'h0};
      exp_p = model32(a, b, sm);
      op32(a, b, sm, hi, lo, lat, bm);
      n_checks++;
      if ({hi, lo} !== exp_p || lat != 34 || bm !== 1'b1) begin
        n_errors++;
        $display("FAIL rand32 a=%h b=%h sm=%b got %h%h lat=%0d busy=%b exp %h lat=34 busy=1",
                 a, b, sm, hi, lo, lat, bm, exp_p);
      end
      @(negedge clk);
      n_checks++;
      if (bus32.done !== 1'b0 || bus32.busy !== 1'b0) begin
        n_errors++;
        $display("FAIL done_pulse got done=%b busy=%b exp 0 0", bus32.done, bus32.busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bus32.aInput = 32'd5; bus32.bInput = 32'd6; bus32.signed_mode = 1'b0; bus32.start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
      bus32.aInput = $urandom; bus32.bInput = $urandom; bus32.signed_mode = 1'($urandom);
    end while (bus32.done !== 1'b1 && lat < 100);
    n_checks++;
    if (lat != 34 || bus32.HI !== 32'h0 || bus32.LO !== 32'd30) begin
      n_errors++;
      $display("FAIL hold_start got lat=%0d HI=%h LO=%h exp lat=34 HI=0 LO=1e", lat, bus32.HI, bus32.LO);
    end
    bus32.aInput = 32'd3; bus32.bInput = 32'd9; bus32.signed_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus32.start = 1'b0;
    n_checks++;
    if (bus32.busy !== 1'b1 || bus32.done !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_restart got busy=%b done=%b exp busy=1 done=0", bus32.busy, bus32.done);
    end
    lat = 1;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (bus32.done !== 1'b1 && lat < 100);
    n_checks++;
    if (lat != 34 || bus32.HI !== 32'h0 || bus32.LO !== 32'd27) begin
      n_errors++;
      $display("FAIL b2b_second got lat=%0d HI=%h LO=%h exp lat=34 HI=0 LO=1b", lat, bus32.HI, bus32.LO);
    end
  endtask

  task automatic test_abort();
    logic [31:0] hi, lo;
    int lat, n_done;
    logic bm;
    op32(32'd5, 32'd6, 1'b0, hi, lo, lat, bm);
    @(negedge clk);
    bus32.aInput = 32'h1234_5678; bus32.bInput = 32'h9ABC_DEF0; bus32.signed_mode = 1'b1;
    bus32.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (9) @(negedge clk);
    bus32.abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus32.abort = 1'b0;
    n_checks++;
    if (bus32.busy !== 1'b0 || bus32.done !== 1'b0 || bus32.HI !== 32'h0 || bus32.LO !== 32'd30) begin
      n_errors++;
      $display("FAIL abort got busy=%b done=%b HI=%h LO=%h exp 0 0 0 1e",
               bus32.busy, bus32.done, bus32.HI, bus32.LO);
    end
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.done === 1'b1 || bus32.busy === 1'b1) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_errors++;
      $display("FAIL abort_quiet got %0d active cycles exp 0", n_done);
    end
    bus32.start = 1'b1; bus32.abort = 1'b1;
    @(negedge clk);
    bus32.start = 1'b0; bus32.abort = 1'b0;
    n_checks++;
    if (bus32.busy !== 1'b0 || bus32.LO !== 32'd30) begin
      n_errors++;
      $display("FAIL abort_prio got busy=%b LO=%h exp busy=0 LO=1e", bus32.busy, bus32.LO);
    end
  endtask

  task automatic test_reset_midrun();
    int lat;
    @(negedge clk);
    bus32.aInput = 32'hDEAD; bus32.bInput = 32'hBEEF; bus32.signed_mode = 1'b0; bus32.start = 1'b1;
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({bus32.busy, bus32.done, bus32.HI, bus32.LO} !== '0) begin
      n_errors++;
      $display("FAIL reset_midrun got busy=%b done=%b HI=%h LO=%h exp all zero",
               bus32.busy, bus32.done, bus32.HI, bus32.LO);
    end
    @(negedge clk);
    bus32.aInput = 32'd11; bus32.bInput = 32'd13; bus32.start = 1'b1;
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus32.start = 1'b0;
    n_checks++;
    if (bus32.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL first_start got busy=%b exp 1", bus32.busy);
    end
    lat = 1;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (bus32.done !== 1'b1 && lat < 100);
    n_checks++;
    if (lat != 34 || bus32.HI !== 32'h0 || bus32.LO !== 32'd143) begin
      n_errors++;
      $display("FAIL post_reset got lat=%0d HI=%h LO=%h exp lat=34 HI=0 LO=8f", lat, bus32.HI, bus32.LO);
    end
  endtask

  task automatic test_width8();
    logic [7:0] a, b, hi, lo;
    logic [15:0] exp_p;
    logic sm;
    int lat;
    op8(8'h80, 8'h7F, 1'b1, hi, lo, lat);
    n_checks++;
    if (lat != 10 || hi !== 8'hC0 || lo !== 8'h80) begin
      n_errors++;
      $display("FAIL w8_signed got lat=%0d HI=%h LO=%h exp lat=10 HI=c0 LO=80", lat, hi, lo);
    end
    op8(8'hFF, 8'hFF, 1'b0, hi, lo, lat);
    n_checks++;
    if (hi !== 8'hFE || lo !== 8'h01) begin
      n_errors++;
      $display("FAIL w8_unsigned got HI=%h LO=%h exp HI=fe LO=01", hi, lo);
    end
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
      exp_p = model8(a, b, sm);
      op8(a, b, sm, hi, lo, lat);
      n_checks++;
      if ({hi, lo} !== exp_p || lat != 10) begin
        n_errors++;
        $display("FAIL rand8 a=%h b=%h sm=%b got %h%h lat=%0d exp %h lat=10", a, b, sm, hi, lo, lat, exp_p);
      end
    end
  endtask

  initial begin
    bus32.start = 1'b0; bus32.abort = 1'b0; bus32.signed_mode = 1'b0;
    bus32.aInput = '0;  bus32.bInput = '0;
    bus8.start  = 1'b0; bus8.abort  = 1'b0; bus8.signed_mode  = 1'b0;
    bus8.aInput  = '0;  bus8.bInput  = '0;
    test_reset();
    test_directed32();
    test_random32();
    test_back_to_back();
    test_abort();
    test_reset_midrun();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
